gate_request_dispatcher: RTL
============================

Name: gate_request_dispatcher

Overview:
Upstream feeder for the gate builder stage. It accepts gate-placement requests from the computer-character AI, buffers them in a small FIFO, and bounds-checks each against the screen. It then drives the gate builder one request at a time using an enable/done handshake. It also produces the VGA plot strobe that qualifies the builder's pixel stream.

Parameters:
DEPTH, 4, FIFO entries; power of two, minimum 2.
LENGTH, 15, gate length in pixels; must match the builder's LENGTH.
X_MAX, 639, largest legal x pixel coordinate.
Y_MAX, 479, largest legal y pixel coordinate.

Ports:
iClock  in  1  system clock
iReset  in  1  synchronous, active-high reset
iReqValid  in  1  request offered this cycle
oReqReady  out  1  FIFO can accept; request taken when iReqValid && oReqReady
iReqX  in  11  gate start x
iReqY  in  11  gate start y
iReqVertical  in  1  1 = grows in +y, 0 = grows in +x
iReqColour  in  3  gate colour
oGateEnable  out  1  enable to gate builder
oGateX  out  11  start x to builder
oGateY  out  11  start y to builder
oGateVertical  out  1  orientation to builder
oGateColour  out  3  colour to builder
iGateDone  in  1  builder finished; stays high while oGateEnable is high
oPlot  out  1  VGA write strobe for builder pixel outputs
oBusy  out  1  FIFO non-empty or FSM not IDLE
oDropCount  out  8  count of requests rejected by the bounds check; saturating

Behaviour:
- Reset: FIFO empty, FSM in IDLE. All outputs are 0, except oReqReady = 1.
- Bounds check at enqueue:
  - Accepted requests are checked combinationally.
  - Horizontal requests are legal iff iReqX + LENGTH - 1 <= X_MAX and iReqY <= Y_MAX.
  - Vertical requests are legal iff iReqY + LENGTH - 1 <= Y_MAX and iReqX <= X_MAX.
  - Sums use 12-bit arithmetic, so there is no wrap.
  - Illegal requests are handshaken (consumed) but not stored; oDropCount increments and saturates at 255.
- FIFO:
  - Holds {x, y, vertical, colour}.
  - oReqReady = !full.
  - A simultaneous legal enqueue and dequeue when full is not possible, because ready is low when full.
  - A simultaneous enqueue and dequeue when non-full is allowed, and the count is unchanged.
  - Pointers wrap modulo DEPTH.
- FSM has four states:
  - IDLE: if FIFO non-empty, pop the head into the output registers oGateX/Y/Vertical/Colour, then go to LOAD.
  - LOAD: oGateEnable = 1 for the first cycle; the builder captures coordinates. oPlot = 0. Go to DRAW next cycle.
  - DRAW: oGateEnable = 1 and oPlot = 1. When iGateDone = 1, drop oPlot and oGateEnable in the same registered update, then go to RELEASE.
  - RELEASE: oGateEnable = 0 for exactly one cycle so the builder clears its counter. Then return to IDLE.
- Output registers are stable from the IDLE pop until the next pop, and do not change during LOAD/DRAW/RELEASE.
- Minimum request-to-request spacing is therefore LENGTH + 3 cycles with a cooperative builder.
- If iGateDone is asserted in LOAD, it is ignored. A stale done is impossible after RELEASE.
- If iGateDone never arrives, the FSM stays in DRAW. There is no timeout.
- Reset mid-operation: FSM returns to IDLE and oGateEnable/oPlot drop on the next edge. FIFO contents are discarded and oDropCount is cleared.
- oBusy = (count != 0) || (state != IDLE).

Test Plan:
- Reset, then a single horizontal request (x=100, y=50, colour=3), with a builder model asserting done 15 cycles after enable. Required response:
  - oGateEnable rises 2 cycles after acceptance, with oGateX=100, oGateY=50.
  - oPlot is high for exactly the DRAW cycles.
  - Enable is low for exactly 1 cycle after done, then oBusy = 0.
- Five back-to-back requests with DEPTH=4 and the builder stalled. Required response:
  - The first is popped.
  - oReqReady goes low after four more are stored.
  - All five are later dispatched in order with correct coordinates.
- Horizontal request x=626: 626+14 = 640 > 639, so it is dropped and oDropCount = 1. Horizontal request x=625 is accepted.
- Vertical request y=466 is dropped; vertical request y=465, x=639 is accepted. Check oGateVertical = 1 on the accepted one.
- Assert iReset during DRAW. Required response:
  - Next cycle, oGateEnable = 0, oPlot = 0, oBusy = 0, oDropCount = 0 and oReqReady = 1.
  - A new request then dispatches normally.
- 300 illegal requests: oDropCount saturates at 255, and the FSM remains IDLE throughout.

Source files
------------

// File: rtl/gate_request_dispatcher.sv
`default_nettype none
// ============================================================================
//  Module   : gate_request_dispatcher
//  Purpose  : Buffers bounds-checked gate-placement requests in a small FIFO
//             and feeds them one at a time to the gate builder. Uses an
//             enable/done handshake and qualifies the builder's pixel stream
//             with a plot strobe.
//  Revision : 1.0 - initial release
// ============================================================================
module gate_request_dispatcher #(
    parameter int DEPTH  = 4,
    parameter int LENGTH = 15,
    parameter int X_MAX  = 639,
    parameter int Y_MAX  = 479
) (
    input  logic        iClock,
    input  logic        iReset,
    input  logic        iReqValid,
    output logic        oReqReady,
    input  logic [10:0] iReqX,
    input  logic [10:0] iReqY,
    input  logic        iReqVertical,
    input  logic [2:0]  iReqColour,
    output logic        oGateEnable,
    output logic [10:0] oGateX,
    output logic [10:0] oGateY,
    output logic        oGateVertical,
    output logic [2:0]  oGateColour,
    input  logic        iGateDone,
    output logic        oPlot,
    output logic        oBusy,
    output logic [7:0]  oDropCount
);

    localparam int                 c_ptr_w  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                 c_cnt_w  = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_depth  = c_cnt_w'(DEPTH);
    localparam logic [11:0]        c_len_m1 = 12'(LENGTH - 1);
    localparam logic [11:0]        c_x_max  = 12'(X_MAX);
    localparam logic [11:0]        c_y_max  = 12'(Y_MAX);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD    = 2'd1,
        S_DRAW    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    logic [25:0]        r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    state_t             r_state;
    state_t             w_state_next;
    logic               w_full;
    logic               w_take;
    logic               w_legal;
    logic               w_push;
    logic               w_pop;
    logic [11:0]        w_x_end;
    logic [11:0]        w_y_end;
    logic [25:0]        w_head;
    logic               r_enable;
    logic               r_plot;
    logic               w_enable_next;
    logic               w_plot_next;
    logic [10:0]        r_gate_x;
    logic [10:0]        r_gate_y;
    logic               r_gate_vertical;
    logic [2:0]         r_gate_colour;
    logic [7:0]         r_drop_count;

    // Far end of the gate computed one bit wider than the inputs so it never wraps
    assign w_x_end = {1'b0, iReqX} + c_len_m1;
    assign w_y_end = {1'b0, iReqY} + c_len_m1;
    assign w_legal = iReqVertical ? ((w_y_end <= c_y_max) && ({1'b0, iReqX} <= c_x_max))
                                  : ((w_x_end <= c_x_max) && ({1'b0, iReqY} <= c_y_max));

    assign w_full  = (r_count == c_depth);
    assign w_take  = iReqValid && !w_full;
    assign w_push  = w_take && w_legal;
    assign w_head  = r_mem[r_rd_ptr];

    // FIFO storage; contents are meaningless until counted, so no reset needed
    always_ff @(posedge iClock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {iReqX, iReqY, iReqVertical, iReqColour};
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge iClock) begin
        if (iReset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_cnt_w'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - c_cnt_w'(1);
            end
        end
    end

    // Saturating count of requests rejected by the bounds check
    always_ff @(posedge iClock) begin
        if (iReset) begin
            r_drop_count <= '0;
        end else if (w_take && !w_legal && (r_drop_count != 8'hFF)) begin
            r_drop_count <= r_drop_count + 8'd1;
        end
    end

    // State register plus registered enable/plot so both drop on the same edge
    always_ff @(posedge iClock) begin
        if (iReset) begin
            r_state  <= S_IDLE;
            r_enable <= 1'b0;
            r_plot   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_enable <= w_enable_next;
            r_plot   <= w_plot_next;
        end
    end

    // Next-state, pop decision and next enable/plot values
    always_comb begin
        w_state_next  = r_state;
        w_pop         = 1'b0;
        w_enable_next = r_enable;
        w_plot_next   = r_plot;
        case (r_state)
            S_IDLE: begin
                if (r_count != '0) begin
                    w_pop         = 1'b1;
                    w_state_next  = S_LOAD;
                    w_enable_next = 1'b1;
                    w_plot_next   = 1'b0;
                end
            end
            S_LOAD: begin
                // A done seen here is ignored: the builder has not started yet
                w_state_next  = S_DRAW;
                w_enable_next = 1'b1;
                w_plot_next   = 1'b1;
            end
            S_DRAW: begin
                if (iGateDone) begin
                    w_state_next  = S_RELEASE;
                    w_enable_next = 1'b0;
                    w_plot_next   = 1'b0;
                end
            end
            S_RELEASE: begin
                w_state_next  = S_IDLE;
                w_enable_next = 1'b0;
                w_plot_next   = 1'b0;
            end
            default: begin
                w_state_next  = S_IDLE;
                w_enable_next = 1'b0;
                w_plot_next   = 1'b0;
            end
        endcase
    end

    // Gate parameters held from one pop until the next
    always_ff @(posedge iClock) begin
        if (iReset) begin
            r_gate_x        <= '0;
            r_gate_y        <= '0;
            r_gate_vertical <= 1'b0;
            r_gate_colour   <= '0;
        end else if (w_pop) begin
            {r_gate_x, r_gate_y, r_gate_vertical, r_gate_colour} <= w_head;
        end
    end

    assign oReqReady     = !w_full;
    assign oGateEnable   = r_enable;
    assign oPlot         = r_plot;
    assign oGateX        = r_gate_x;
    assign oGateY        = r_gate_y;
    assign oGateVertical = r_gate_vertical;
    assign oGateColour   = r_gate_colour;
    assign oDropCount    = r_drop_count;
    assign oBusy         = (r_count != '0) || (r_state != S_IDLE);

endmodule
`default_nettype wire
